// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - March-test BIST initiator for the synchronous dual-port RAM
//
// Runs a 4-element march over every address on a start pulse:
//   M0 up   : write P
//   M1 up   : read (expect P),  write ~P
//   M2 down : read (expect ~P), write P
//   M3 up   : read (expect P)
// It stops at the first mismatch and reports the address and march element.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start         start request, honoured only in IDLE or DONE
//   busy, done    test running / test finished (done sticky until start or reset)
//   pass          valid with done; 1 when no mismatch was seen
//   fail_addr     address of the first mismatch (0 on pass)
//   fail_phase    march element of the first mismatch, 1..3 (0 on pass)
//   mem_we/mem_re RAM write / read enables, never both high
//   mem_wr_addr, mem_rd_addr, mem_wdata  RAM write/read address and write data
//   mem_rdata     RAM registered read data, one cycle after mem_re

module ram_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter     PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_phase,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DATA_WIDTH-1:0] PAT       = DATA_WIDTH'(PATTERN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, M0_WR, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CHK, DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   cmp_addr;   // address whose read data arrives this cycle in M3
  logic                    cmp_valid;  // M3 has issued at least one read
  logic                    chk_en;
  logic [DATA_WIDTH-1:0]   chk_exp;
  logic [ADDR_WIDTH-1:0]   chk_addr;
  logic [1:0]              chk_phase;
  logic                    mismatch;
  logic                    addr_last;
  logic                    addr_first;

  assign addr_last   = (addr == ADDR_LAST);
  assign addr_first  = (addr == '0);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign mem_wr_addr = addr;
  assign mem_rd_addr = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_wdata  = '0;
    chk_en     = 1'b0;
    chk_exp    = PAT;
    chk_addr   = addr;
    chk_phase  = 2'd0;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = M0_WR;
      end
      M0_WR: begin
        mem_we    = 1'b1;
        mem_wdata = PAT;
        if (addr_last) next_state = M1_RD;
      end
      M1_RD: begin
        mem_re     = 1'b1;
        next_state = M1_WR;
      end
      M1_WR: begin
        // Read data for this address arrives now, alongside the inverse write.
        mem_we     = 1'b1;
        mem_wdata  = ~PAT;
        chk_en     = 1'b1;
        chk_exp    = PAT;
        chk_phase  = 2'd1;
        next_state = addr_last ? M2_RD : M1_RD;
      end
      M2_RD: begin
        mem_re     = 1'b1;
        next_state = M2_WR;
      end
      M2_WR: begin
        mem_we     = 1'b1;
        mem_wdata  = PAT;
        chk_en     = 1'b1;
        chk_exp    = ~PAT;
        chk_phase  = 2'd2;
        next_state = addr_first ? M3_RD : M2_RD;
      end
      M3_RD: begin
        // Pipelined: read addr while checking the previous address's data.
        mem_re     = 1'b1;
        chk_en     = cmp_valid;
        chk_addr   = cmp_addr;
        chk_phase  = 2'd3;
        if (addr_last) next_state = M3_CHK;
      end
      M3_CHK: begin
        chk_en     = 1'b1;
        chk_addr   = cmp_addr;
        chk_phase  = 2'd3;
        next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
    mismatch = chk_en && (mem_rdata != chk_exp);
    if (mismatch) next_state = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      cmp_addr   <= '0;
      cmp_valid  <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_phase <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr       <= '0;
            cmp_valid  <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_phase <= 2'd0;
          end
        end
        M0_WR: addr <= addr_last ? '0 : addr + ADDR_ONE;
        // M1 ends on the top address, which is exactly where M2 starts.
        M1_WR: if (!addr_last) addr <= addr + ADDR_ONE;
        // M2 ends on address 0, which is exactly where M3 starts.
        M2_WR: if (!addr_first) addr <= addr - ADDR_ONE;
        M3_RD: begin
          cmp_addr  <= addr;
          cmp_valid <= 1'b1;
          if (!addr_last) addr <= addr + ADDR_ONE;
        end
        M3_CHK: if (!mismatch) pass <= 1'b1;
        default: ;
      endcase
      if (mismatch) begin
        fail_addr  <= chk_addr;
        fail_phase <= chk_phase;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - Randomized model-checked bench for ram_bist with a faultable RAM model

module tb_ram_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam logic [7:0] P = 8'h55;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [1:0]    fail_phase;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PATTERN(8'h55)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_phase(fail_phase), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM model with injectable faults: stuck bit on one word, or a one-bit flip on the n-th read.
  logic [7:0] ram [D];
  logic [7:0] rdata_q = 8'h00;
  int         rd_total = 0;
  bit         stuck_en = 0;
  int         stuck_a = 0;
  int         stuck_bit = 0;
  logic       stuck_val = 1'b0;
  bit         flip_en = 0;
  int         flip_abs = 0;

  function automatic logic [7:0] fault_rd(input logic [7:0] v, input int a, input int n);
    logic [7:0] r;
    r = v;
    if (stuck_en && a == stuck_a) r[stuck_bit] = stuck_val;
    if (flip_en && n == flip_abs) r = r ^ 8'h01;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we && !mem_re) ram[mem_wr_addr] <= mem_wdata;
    if (mem_re && !mem_we) begin
      rdata_q  <= fault_rd(ram[mem_rd_addr], int'(mem_rd_addr), rd_total);
      rd_total <= rd_total + 1;
    end
  end
  assign mem_rdata = rdata_q;

  // Protocol monitor
  int n_we = 0, n_re = 0, n_both = 0;
  always @(negedge clk) begin
    if (mem_we) n_we++;
    if (mem_re) n_re++;
    if (mem_we && mem_re) n_both++;
  end

  // Behavioural model: the list of RAM operations the march must produce, cycle by cycle.
  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] a;
    logic [7:0] d;
  } op_t;

  op_t        ops[$];
  bit         exp_pass;
  logic [3:0] exp_fa;
  logic [1:0] exp_fp;
  logic [7:0] mdl_mem [D];
  int         exp_nwe, exp_nre;

  function automatic op_t mk(input logic we, input logic re, input int a, input logic [7:0] d);
    op_t o;
    o.we = we; o.re = re; o.a = 4'(a); o.d = d;
    return o;
  endfunction

  task automatic build_model();
    logic [7:0] mm [D];
    logic [7:0] v;
    int rn;
    bit failed;
    ops.delete();
    rn = 0; failed = 0; exp_fa = '0; exp_fp = '0;
    for (int a = 0; a < D; a++) mm[a] = ram[a];
    for (int a = 0; a < D; a++) begin
      ops.push_back(mk(1, 0, a, P)); mm[a] = P;
    end
    for (int a = 0; a < D && !failed; a++) begin
      ops.push_back(mk(0, 1, a, 8'h00));
      v = fault_rd(mm[a], a, rd_total + rn); rn++;
      ops.push_back(mk(1, 0, a, ~P)); mm[a] = ~P;
      if (v !== P) begin failed = 1; exp_fa = 4'(a); exp_fp = 2'd1; end
    end
    for (int a = D - 1; a >= 0 && !failed; a--) begin
      ops.push_back(mk(0, 1, a, 8'h00));
      v = fault_rd(mm[a], a, rd_total + rn); rn++;
      ops.push_back(mk(1, 0, a, P)); mm[a] = P;
      if (v !== ~P) begin failed = 1; exp_fa = 4'(a); exp_fp = 2'd2; end
    end
    for (int a = 0; a < D && !failed; a++) begin
      ops.push_back(mk(0, 1, a, 8'h00));
      v = fault_rd(mm[a], a, rd_total + rn); rn++;
      if (v !== P) begin
        failed = 1; exp_fa = 4'(a); exp_fp = 2'd3;
        if (a < D - 1) ops.push_back(mk(0, 1, a + 1, 8'h00));
      end
    end
    // final compare-only cycle
    if (!failed || (exp_fp == 2'd3 && exp_fa == 4'(D - 1))) ops.push_back(mk(0, 0, 0, 8'h00));
    exp_pass = !failed;
    exp_nwe = 0; exp_nre = 0;
    foreach (ops[i]) begin
      if (ops[i].we) exp_nwe++;
      if (ops[i].re) exp_nre++;
    end
    for (int a = 0; a < D; a++) mdl_mem[a] = mm[a];
  endtask

  // Compare process
  bit  chk_on = 0;
  int  pos = 0;
  op_t o;
  always @(negedge clk) begin
    if (!chk_on) begin
      pos = 0;
    end else if (pos < ops.size()) begin
      o = ops[pos];
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("result_cleared", {pass, fail_addr, fail_phase}, 0);
      chk("mem_we", mem_we, o.we);
      chk("mem_re", mem_re, o.re);
      if (o.we) begin
        chk("wr_addr", mem_wr_addr, o.a);
        chk("wdata", mem_wdata, o.d);
      end
      if (o.re) chk("rd_addr", mem_rd_addr, o.a);
      pos++;
    end else begin
      chk("busy_after", busy, 0);
      chk("done", done, 1);
      chk("idle_we_re", {mem_we, mem_re}, 0);
      chk("pass", pass, exp_pass);
      chk("fail_addr", fail_addr, exp_fa);
      chk("fail_phase", fail_phase, exp_fp);
    end
  end

  int r_nwe, r_nre;

  task automatic check_all_zero(input string nm);
    chk({nm, "_flags"}, {busy, done, pass, mem_we, mem_re}, 0);
    chk({nm, "_fail"}, {fail_addr, fail_phase}, 0);
    chk({nm, "_bus"}, {mem_wr_addr, mem_rd_addr, mem_wdata}, 0);
  endtask

  task automatic run(input int flip_n, input int mid_start, input int abort_at, output int cyc);
    int nwe0, nre0;
    @(posedge clk); #1;
    chk_on   = 0;
    flip_en  = (flip_n >= 0);
    flip_abs = rd_total + flip_n;
    build_model();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("done_cleared", done, 0);
    chk("pass_cleared", pass, 0);
    nwe0 = n_we; nre0 = n_re;
    chk_on = 1;
    cyc = 0;
    while (cyc < 2000 && !done) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid_start);
      if (cyc == abort_at) begin
        chk_on = 0;
        start  = 0;
        #2 rst = 0;
        #1 check_all_zero("async_reset");
        return;
      end
    end
    start = 0;
    chk("done_in_time", done, 1);
    chk("cycles", cyc, ops.size());
    r_nwe = n_we - nwe0;
    r_nre = n_re - nre0;
    chk("writes", r_nwe, exp_nwe);
    chk("reads", r_nre, exp_nre);
    repeat (10) @(posedge clk);
    chk("no_access_after_done", (n_we - nwe0) + (n_re - nre0), exp_nwe + exp_nre);
    chk("no_we_re_overlap", n_both, 0);
    for (int a = 0; a < D; a++) chk("ram_word", ram[a], mdl_mem[a]);
  endtask

  int cyc;

  initial begin
    rst = 0;
    start = 0;
    for (int a = 0; a < D; a++) ram[a] = 8'($urandom);
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (5) @(posedge clk);

    // Fault-free run
    run(-1, -1, -1, cyc);
    chk("t1_cycles", cyc, 97);
    chk("t1_result", {pass, fail_addr, fail_phase}, {1'b1, 4'd0, 2'd0});
    chk("t1_writes", r_nwe, 48);
    chk("t1_reads", r_nre, 48);
    for (int a = 0; a < D; a++) chk("t1_ram_55", ram[a], 8'h55);

    // start while busy is ignored
    run(-1, 40, -1, cyc);
    chk("busy_start_cycles", cyc, 97);
    chk("busy_start_pass", pass, 1);

    // start straight from DONE
    run(-1, -1, -1, cyc);
    chk("rerun_cycles", cyc, 97);

    // Stuck-at-1 on bit 0 of word 5
    stuck_en = 1; stuck_a = 5; stuck_bit = 0; stuck_val = 1'b1;
    run(-1, -1, -1, cyc);
    stuck_en = 0;
    chk("stuck_result", {pass, fail_addr, fail_phase}, {1'b0, 4'd5, 2'd2});
    chk("stuck_cycles", cyc, 70);

    // Flip on the final M3 read (word 15)
    run(47, -1, -1, cyc);
    chk("flip_result", {pass, fail_addr, fail_phase}, {1'b0, 4'd15, 2'd3});
    chk("flip_cycles", cyc, 97);

    // Asynchronous reset mid-M2, then a clean run
    run(-1, -1, 60, cyc);
    repeat (3) @(posedge clk);
    check_all_zero("held_reset");
    #1 rst = 1;
    run(-1, -1, -1, cyc);
    chk("post_reset_cycles", cyc, 97);
    chk("post_reset_pass", pass, 1);

    // Randomized faults and mid-run start pulses
    for (int i = 0; i < 8; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      stuck_en  = (kind == 1);
      stuck_a   = $urandom_range(0, D - 1);
      stuck_bit = $urandom_range(0, 7);
      stuck_val = 1'($urandom_range(0, 1));
      run((kind == 2) ? int'($urandom_range(0, 3 * D - 1)) : -1,
          $urandom_range(1, 120), -1, cyc);
      stuck_en = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the team's synchronous dual-port RAM. It drives that RAM's write and read ports.
- On a start pulse it runs a 4-element march test over every address. It writes a pattern, then its inverse, and checks each read-back against the expected value.
- It reports pass/fail, the first failing address and the march element that failed.
- It sits beside the RAM instance and muxes onto its ports in test mode. The mux is not part of this block.

Parameters:
- DATA_WIDTH, 8, RAM word width; must match the RAM.
- ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH.
- PATTERN, 8'h55, background pattern P, zero-extended or truncated to DATA_WIDTH; ~P is its bitwise inverse.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start request, sampled only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test finished; sticky until next start or reset.
- pass  out  1  valid when done=1; 1 means no mismatch.
- fail_addr  out  ADDR_WIDTH  address of first mismatch; 0 if pass.
- fail_phase  out  2  march element of first mismatch (1, 2 or 3); 0 if pass.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_wr_addr  out  ADDR_WIDTH  RAM write address.
- mem_rd_addr  out  ADDR_WIDTH  RAM read address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM registered read data (1-cycle latency).

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0 and the FSM goes to IDLE. This applies mid-test too: mem_we and mem_re drop immediately with no further RAM access. RAM contents are left as-is.
- RAM contract:
  - RAM writes only when we=1 and re=0, and reads only when re=1 and we=0.
  - The block never asserts mem_we and mem_re in the same cycle.
  - Read data for a read issued in cycle n is valid on mem_rdata in cycle n+1.
- States: IDLE, M0_WR, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CHK, DONE.
- IDLE/DONE + start=1: go to M0_WR with addr=0. This clears done, pass, fail_addr and fail_phase, and sets busy=1. start is ignored in all other states.
- M0_WR (ascending): mem_we=1, writes P to addr, one address per cycle. After DEPTH-1, go to M1_RD with addr=0.
- M1 (ascending, 2 cycles per address):
  - M1_RD: mem_re=1 at addr.
  - M1_WR: mem_we=1, writes ~P to addr; compares mem_rdata with P in the same cycle.
  - After DEPTH-1, go to M2_RD with addr=DEPTH-1.
- M2 (descending): same as M1 but expects ~P and writes P. After addr 0, go to M3_RD with addr=0.
- M3_RD (ascending): mem_re=1, one address per cycle.
  - From the second cycle on, mem_rdata is compared with P for the previous address (held in a registered compare address).
  - After DEPTH-1, go to M3_CHK, which compares the last address with mem_re=0, then goes to DONE.
- Mismatch:
  - Any write scheduled in that cycle still occurs.
  - On the next edge: DONE, pass=0, fail_addr = address compared, fail_phase = element (1, 2 or 3). The test stops on the first failure.
- DONE: busy=0, done=1, mem_we=mem_re=0. pass=1 if no mismatch occurred.
- Timing: with no failure, done rises on the edge 6*DEPTH+1 clocks after the edge that sampled start. For ADDR_WIDTH=4 this is 97; for 8 it is 1537.
- Addresses wrap nowhere. Counters stop at the range ends, and transitions occur on DEPTH-1 (ascending) or 0 (descending).
- mem_wdata, mem_wr_addr and mem_rd_addr are don't-care when their enable is 0, but must be X-free after reset.

Test Plan:
- Fault-free RAM (ADDR_WIDTH=4), start pulse at cycle 10 → busy for 97 cycles, done=1, pass=1, fail_addr=0, fail_phase=0; all 16 RAM words end as 8'h55.
- Stuck-at-1 on bit 0 of word 5 (bench RAM model) → M1 passes (P=0x55); M2 reads 0xAB vs 0xAA → pass=0, fail_addr=5, fail_phase=2; no RAM access after failure.
- Bench flips mem_rdata only for the final M3 read of word 15 → detected in M3_CHK: fail_addr=15, fail_phase=3, done at cycle 97.
- Protocol monitor across a full run → mem_we&mem_re never both 1; exactly 3*DEPTH writes and 3*DEPTH reads; M2 addresses strictly descending.
- start asserted while busy → ignored, done timing unchanged; start in DONE → new run, done/pass cleared on the next edge.
- rst pulled low mid-M2 (asynchronous, between edges) → all outputs 0 immediately; after release, start → full passing run of 97 cycles.
